// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel-tick divider, h/v counters, registered sync/video flags, graceful run/stop.
// Define VGA_FRAME_COUNTER_EN to add the 16-bit completed-frame counter output frame_cnt.
module vga_timing_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic        busy
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DW-1:0] DIV_M1   = DW'(TICK_DIV - 1);
  localparam logic [9:0]    HT_M1    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VT_M1    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]    VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]    HV       = 10'(H_VISIBLE);
  localparam logic [9:0]    VV       = 10'(V_VISIBLE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div, div_nx;
  logic [9:0]    x_nx, y_nx;
  logic          eof, fs_nx, busy_nx, tick_nx, hs_nx, vs_nx, vid_nx;

  // Next-state values are computed here and registered below, so every
  // output flag lines up with the pixel_x/pixel_y it describes.
  always_comb begin
    state_nx = state;
    div_nx   = div;
    x_nx     = pixel_x;
    y_nx     = pixel_y;
    fs_nx    = 1'b0;
    eof      = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = RUN;
          fs_nx    = 1'b1;
        end
      end
      RUN, DRAIN: begin
        eof    = pix_tick && (pixel_x == HT_M1) && (pixel_y == VT_M1);
        div_nx = (div == DIV_M1) ? '0 : div + 1'b1;
        if (pix_tick) begin
          if (pixel_x == HT_M1) begin
            x_nx = '0;
            y_nx = (pixel_y == VT_M1) ? '0 : pixel_y + 10'd1;
          end else begin
            x_nx = pixel_x + 10'd1;
          end
        end
        // A run request at the final tick of a drain keeps the raster going seamlessly.
        if (eof && (state == DRAIN) && !en) begin
          state_nx = IDLE;
          div_nx   = '0;
          x_nx     = '0;
          y_nx     = '0;
        end else begin
          state_nx = en ? RUN : DRAIN;
          fs_nx    = eof;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
    tick_nx = busy_nx && (div_nx == DIV_M1);
    hs_nx   = !(busy_nx && (x_nx >= HS_START) && (x_nx < HS_END));
    vs_nx   = !(busy_nx && (y_nx >= VS_START) && (y_nx < VS_END));
    vid_nx  = busy_nx && (x_nx < HV) && (y_nx < VV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      div         <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pix_tick    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      div         <= div_nx;
      pixel_x     <= x_nx;
      pixel_y     <= y_nx;
      pix_tick    <= tick_nx;
      hsync       <= hs_nx;
      vsync       <= vs_nx;
      video_on    <= vid_nx;
      frame_start <= fs_nx;
      busy        <= busy_nx;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  // Counts every completed frame, including the last one of a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else       frame_cnt <= frame_cnt + {15'd0, eof};
  end
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: two small-raster instances (TICK_DIV 2 and 1) checked every cycle
// against a frame-time-index model, plus hand-computed timing literals and randomized en/reset traffic.
module tb_vga_timing_controller;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 15
  localparam int VT = VV + VF + VS + VB;   // 8

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic       tick [2];
  logic       hs   [2];
  logic       vs   [2];
  logic       vid  [2];
  logic [9:0] px   [2];
  logic [9:0] py   [2];
  logic       fs   [2];
  logic       bsy  [2];
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] fc  [2];
`endif

  always #5 clk = ~clk;

  vga_timing_controller #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                          .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .TICK_DIV(2)) u0 (
    .clk(clk), .reset(reset), .en(en), .pix_tick(tick[0]), .hsync(hs[0]), .vsync(vs[0]),
    .video_on(vid[0]), .pixel_x(px[0]), .pixel_y(py[0]), .frame_start(fs[0]), .busy(bsy[0])
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc[0])
`endif
  );

  vga_timing_controller #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                          .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .TICK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .pix_tick(tick[1]), .hsync(hs[1]), .vsync(vs[1]),
    .video_on(vid[1]), .pixel_x(px[1]), .pixel_y(py[1]), .frame_start(fs[1]), .busy(bsy[1])
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc[1])
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a raster is just a clk index t within the frame; everything else is arithmetic on t.
  int          m_t     [2];
  bit          m_act   [2];
  bit          m_fs    [2];
  bit          m_drain [2];
  logic [15:0] m_fc    [2];
  bit          m_eof;

  function automatic int td_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k] = 0; m_t[k] = 0; m_fs[k] = 0; m_drain[k] = 0; m_fc[k] = 16'd0;
      end else if (!m_act[k]) begin
        m_act[k] = en; m_fs[k] = en; m_t[k] = 0; m_drain[k] = 0;
      end else begin
        m_eof = (m_t[k] == td_of(k) * HT * VT - 1);
        if (m_eof) m_fc[k] = m_fc[k] + 16'd1;
        if (m_eof && m_drain[k] && !en) begin
          m_act[k] = 0; m_t[k] = 0; m_fs[k] = 0;
        end else begin
          m_t[k]  = m_eof ? 0 : m_t[k] + 1;
          m_fs[k] = m_eof;
        end
        m_drain[k] = !en;
      end
    end
  end

  int ex, ey, etd;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        etd = td_of(k);
        ex  = m_act[k] ? (m_t[k] / etd) % HT : 0;
        ey  = m_act[k] ? m_t[k] / (etd * HT) : 0;
        check($sformatf("pixel_x[%0d] cyc %0d", k, cyc), px[k], ex);
        check($sformatf("pixel_y[%0d] cyc %0d", k, cyc), py[k], ey);
        check($sformatf("busy[%0d] cyc %0d", k, cyc), bsy[k], m_act[k]);
        check($sformatf("pix_tick[%0d] cyc %0d", k, cyc), tick[k],
              m_act[k] && (m_t[k] % etd == etd - 1));
        check($sformatf("hsync[%0d] cyc %0d", k, cyc), hs[k],
              !(m_act[k] && ex >= HV + HF && ex < HV + HF + HS));
        check($sformatf("vsync[%0d] cyc %0d", k, cyc), vs[k],
              !(m_act[k] && ey >= VV + VF && ey < VV + VF + VS));
        check($sformatf("video_on[%0d] cyc %0d", k, cyc), vid[k], m_act[k] && ex < HV && ey < VV);
        check($sformatf("frame_start[%0d] cyc %0d", k, cyc), fs[k], m_fs[k]);
`ifdef VGA_FRAME_COUNTER_EN
        check($sformatf("frame_cnt[%0d] cyc %0d", k, cyc), fc[k], m_fc[k]);
`endif
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
    cyc++;
  endtask

  task automatic wait_line(input int ln);
    int n;
    n = 0;
    while (!(m_act[0] && m_t[0] / (2 * HT) == ln) && n < 1000) begin
      step();
      n++;
    end
    check($sformatf("wait_line %0d reached", ln), n < 1000, 1);
  endtask

  int hs_lo, vs_lo, vid_n, tick_n, gap0, gap1, hs_x, vs_y, n, start, lx, ly;

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    repeat (3) step();
    chk_on = 1'b1;
    // Reset held with en=1: idle values.
    check("reset hsync", hs[0], 1);
    check("reset vsync", vs[0], 1);
    check("reset busy", bsy[0], 0);
    check("reset video_on", vid[0], 0);
    check("reset pixel_x", px[0], 0);
    check("reset frame_start", fs[0], 0);
    reset = 1'b0;
    step();
    check("first run frame_start", fs[0], 1);
    check("first run busy", bsy[0], 1);
    check("first run pixel_y", py[0], 0);

    // One full frame of u0 (240 clk) measured from its first frame_start.
    hs_lo = 0; vs_lo = 0; vid_n = 0; tick_n = 0; gap0 = 0; gap1 = 0; hs_x = -1; vs_y = -1;
    for (int i = 0; i < 240; i++) begin
      if (!hs[0]) begin hs_lo++; if (hs_x < 0) hs_x = px[0]; end
      if (!vs[0]) begin vs_lo++; if (vs_y < 0) vs_y = py[0]; end
      if (vid[0]) vid_n++;
      if (tick[0]) tick_n++;
      step();
      if (fs[0] && gap0 == 0) gap0 = i + 1;
      if (fs[1] && gap1 == 0) gap1 = i + 1;
    end
    check("frame period td2", gap0, 240);
    check("frame period td1", gap1, 120);
    check("hsync low clk per frame", hs_lo, 48);
    check("hsync first x", hs_x, 10);
    check("vsync low clk per frame", vs_lo, 60);
    check("vsync first y", vs_y, 5);
    check("video_on clk per frame", vid_n, 64);
    check("pix_tick per frame", tick_n, 120);

    // Graceful stop at line 2: finishes the frame, then idle.
    wait_line(2);
    en = 1'b0;
    n = 0; lx = -1; ly = -1;
    while (bsy[0] && n < 600) begin
      lx = px[0]; ly = py[0];
      step();
      n++;
    end
    check("drain cycles to idle", n, 180);
    check("drain last x", lx, 14);
    check("drain last y", ly, 7);
    tick_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (tick[0]) tick_n++;
      step();
    end
    check("ticks while idle", tick_n, 0);
    check("idle hsync", hs[0], 1);

    // Re-enable during drain: no gap between frames.
    en = 1'b1;
    step();
    check("restart frame_start", fs[0], 1);
    start = cyc;
    wait_line(2);
    en = 1'b0;
    wait_line(5);
    en = 1'b1;
    n = 0;
    while (!fs[0] && n < 600) begin
      step();
      n++;
    end
    check("re-enable frame period", cyc - start, 240);

    // Randomized en toggles and occasional mid-frame resets, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b1;
        step();
        check("mid reset busy", bsy[0], 0);
        step();
        reset = 1'b0;
      end
    end

`ifdef VGA_FRAME_COUNTER_EN
    reset = 1'b1; en = 1'b1;
    step();
    reset = 1'b0;
    repeat (2 * 240 + 20) step();
    en = 1'b0;
    n = 0;
    while (bsy[0] && n < 600) begin step(); n++; end
    repeat (5) step();
    check("frame_cnt after 3 frames", fc[0], 3);
    force u0.frame_cnt = 16'hFFFF;
    #1;
    release u0.frame_cnt;
    m_fc[0] = 16'hFFFF;
    step();
    en = 1'b1;
    repeat (10) step();
    en = 1'b0;
    n = 0;
    while (bsy[0] && n < 600) begin step(); n++; end
    check("frame_cnt wrap", fc[0], 0);
`endif

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
